// File: rtl/impulse_frame_deserializer_pkg.sv
// Shared defaults, FSM state encoding and count-word type for the impulse readout deserializer.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package impulse_pkg;

    localparam int IMP_WIDTH  = 8;
    localparam int IMP_NUM_CH = 8;
    localparam int IMP_AW     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef logic [IMP_WIDTH-1:0] count_t;

endpackage

// File: rtl/impulse_frame_deserializer_if.sv
// Bundles the counter serial readout, the host read port and the status outputs of the deserializer.
// Latency: n/a (wiring only).
// Backpressure: none; the readout stream cannot be stalled, so there is no ready signal.
interface impulse_frame_deserializer_if
    import impulse_pkg::*;
#(
    parameter int WIDTH = IMP_WIDTH,
    parameter int AW    = IMP_AW
) ();

    logic             serial_in;
    logic             sl_in;
    logic [AW-1:0]    addr_in;
    logic             ovf_rtc_in;
    logic             ovf_global_in;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             word_valid;
    logic [AW-1:0]    word_addr;
    logic [WIDTH-1:0] word_data;
    logic             frame_err;
    logic             period_tick;
    logic [7:0]       period_cnt;
    logic             ovf_sticky;

    // Counter side / host side: drives the readout stream and the read address.
    modport master (
        output serial_in, sl_in, addr_in, ovf_rtc_in, ovf_global_in, rd_addr,
        input  rd_data, word_valid, word_addr, word_data, frame_err,
               period_tick, period_cnt, ovf_sticky
    );

    // Deserializer side.
    modport slave (
        input  serial_in, sl_in, addr_in, ovf_rtc_in, ovf_global_in, rd_addr,
        output rd_data, word_valid, word_addr, word_data, frame_err,
               period_tick, period_cnt, ovf_sticky
    );

endinterface

// File: rtl/impulse_frame_deserializer_edge_detect.sv
// Rising-edge detector: pulse is high for one cycle when din is high and was low last cycle.
// Latency: combinational pulse against a registered copy of the previous value.
// Backpressure: none; a level held high produces a single pulse.
module impulse_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic din_q;

    // Remember last cycle's level so a held-high input does not re-trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign pulse = din & ~din_q;

endmodule

// File: rtl/impulse_frame_deserializer.sv
// Reassembles MSB-first serial count words into a per-channel register file and flags bad frames.
// Latency: word_valid in the cycle sl_in drops after the last bit; register file readable one cycle later.
// Backpressure: none; malformed frames are dropped with a frame_err pulse instead of stalling.
module impulse_frame_deserializer
    import impulse_pkg::*;
#(
    parameter int WIDTH  = IMP_WIDTH,
    parameter int NUM_CH = IMP_NUM_CH,
    parameter int AW     = IMP_AW
) (
    input logic                        clk,
    input logic                        rst_n,
    impulse_frame_deserializer_if.slave bus
);

    localparam int CNTW = $clog2(WIDTH + 1);
    localparam int IW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] SHIFT = ST_SHIFT;
    localparam logic [1:0] DRAIN = ST_DRAIN;

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CNTW-1:0]  bit_cnt;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] regs [NUM_CH];
    logic [AW-1:0]    word_addr_q;
    logic [WIDTH-1:0] word_data_q;
    logic [7:0]       period_cnt_q;
    logic             ovf_sticky_q;

    logic full;
    logic addr_ok;
    logic rd_ok;
    logic commit;
    logic err;
    logic tick;

    // A frame is complete when exactly WIDTH bits arrived; the address is the one seen with bit 0.
    assign full    = (bit_cnt == CNTW'(WIDTH));
    assign addr_ok = ({1'b0, addr_q} < (AW + 1)'(NUM_CH));
    assign rd_ok   = ({1'b0, bus.rd_addr} < (AW + 1)'(NUM_CH));

    // Commit and error decisions are made in the cycle sl_in is sampled, so the pulses line up with it.
    assign commit = (state == SHIFT) && !bus.sl_in && full && addr_ok;
    assign err    = (state == SHIFT) && (bus.sl_in ? full : !(full && addr_ok));

    // Frame FSM: collect bits, then either return to IDLE or swallow an overlong burst in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            addr_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.sl_in) begin
                        shreg   <= {{(WIDTH-1){1'b0}}, bus.serial_in};
                        bit_cnt <= CNTW'(1);
                        addr_q  <= bus.addr_in;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.sl_in) begin
                        if (full) begin
                            state <= DRAIN;
                        end else begin
                            shreg   <= {shreg[WIDTH-2:0], bus.serial_in};
                            bit_cnt <= bit_cnt + CNTW'(1);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!bus.sl_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-channel result registers, written only by a well-formed frame to an in-range channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[addr_q[IW-1:0]] <= shreg;
        end
    end

    // Hold the last committed word for consumers that sample after the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_addr_q <= '0;
            word_data_q <= '0;
        end else if (commit) begin
            word_addr_q <= addr_q;
            word_data_q <= shreg;
        end
    end

    impulse_edge_detect u_rtc_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.ovf_rtc_in),
        .pulse (tick)
    );

    // Period counter and global-overflow flag; a new overflow in the tick cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt_q <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            if (tick) begin
                period_cnt_q <= period_cnt_q + 8'd1;
            end
            if (bus.ovf_global_in) begin
                ovf_sticky_q <= 1'b1;
            end else if (tick) begin
                ovf_sticky_q <= 1'b0;
            end
        end
    end

    assign bus.rd_data     = rd_ok ? regs[bus.rd_addr[IW-1:0]] : '0;
    assign bus.word_valid  = commit;
    assign bus.word_addr   = commit ? addr_q : word_addr_q;
    assign bus.word_data   = commit ? shreg : word_data_q;
    assign bus.frame_err   = err;
    assign bus.period_tick = tick;
    assign bus.period_cnt  = period_cnt_q;
    assign bus.ovf_sticky  = ovf_sticky_q;

endmodule

// File: tb/tb_impulse_frame_deserializer.sv
// Randomized scoreboard bench for impulse_frame_deserializer.
// Latency: expected events are queued at stimulus time and popped when the DUT pulses.
// Backpressure: none; the bench drives the stream freely.
module tb_impulse_frame_deserializer;
    import impulse_pkg::*;

    typedef struct {
        bit         err;
        logic [3:0] a;
        count_t     d;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    impulse_frame_deserializer_if bus ();

    impulse_frame_deserializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    ev_t    evq[$];
    count_t mem [8];
    logic   m_prev   = 1'b0;
    logic [7:0] m_cnt = 8'd0;
    logic   m_sticky = 1'b0;
    int     tick_seen = 0;
    bit     rand_side = 1'b0;
    bit     rand_rd   = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and refresh the side-band inputs.
    task automatic tick_step();
        @(posedge clk);
        #1;
        if (rand_rd) bus.rd_addr = 4'($urandom_range(0, 15));
        if (rand_side) begin
            if ($urandom_range(0, 9) == 0) bus.ovf_rtc_in = ~bus.ovf_rtc_in;
            bus.ovf_global_in = ($urandom_range(0, 19) == 0);
        end
    endtask

    // One burst of nbits strobed bits; exactly eight bits to a channel below 8 is a word, else one error.
    task automatic send_frame(input logic [3:0] a, input count_t d, input int nbits, input int gap);
        ev_t e;
        e.err = !(nbits == 8 && a < 4'd8);
        e.a   = a;
        e.d   = d;
        evq.push_back(e);
        for (int i = 0; i < nbits; i++) begin
            bus.sl_in     = 1'b1;
            bus.serial_in = (i < 8) ? d[7 - i] : 1'($urandom_range(0, 1));
            bus.addr_in   = (i == 0) ? a : 4'($urandom_range(0, 15));
            tick_step();
        end
        bus.sl_in     = 1'b0;
        bus.serial_in = 1'b0;
        for (int i = 0; i < gap; i++) tick_step();
    endtask

    // Monitor: compares every DUT output against the bench model each cycle.
    ev_t        mon_e;
    bit         mon_commit;
    logic       exp_tick;
    count_t     exp_rd;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev   = 1'b0;
            m_cnt    = 8'd0;
            m_sticky = 1'b0;
            for (int i = 0; i < 8; i++) mem[i] = '0;
            evq.delete();
        end else begin
            mon_commit = 1'b0;
            exp_tick = bus.ovf_rtc_in && !m_prev;
            check("period_tick", bus.period_tick, exp_tick);
            check("period_cnt", bus.period_cnt, m_cnt);
            check("ovf_sticky", bus.ovf_sticky, m_sticky);
            exp_rd = (bus.rd_addr < 4'd8) ? mem[bus.rd_addr[2:0]] : 8'h00;
            check("rd_data", bus.rd_data, exp_rd);
            if (bus.period_tick) tick_seen++;
            if (bus.word_valid || bus.frame_err) begin
                if (evq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_event: word_valid=%0b frame_err=%0b with nothing expected at %0t",
                             bus.word_valid, bus.frame_err, $time);
                end else begin
                    mon_e = evq.pop_front();
                    check("event_frame_err", bus.frame_err, mon_e.err);
                    check("event_word_valid", bus.word_valid, !mon_e.err);
                    if (!mon_e.err) begin
                        check("word_addr", bus.word_addr, mon_e.a);
                        check("word_data", bus.word_data, mon_e.d);
                        mon_commit = 1'b1;
                    end
                end
            end
            if (bus.ovf_global_in) m_sticky = 1'b1;
            else if (exp_tick)     m_sticky = 1'b0;
            if (exp_tick) m_cnt = m_cnt + 8'd1;
            m_prev = bus.ovf_rtc_in;
            if (mon_commit) mem[mon_e.a[2:0]] = mon_e.d;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", compared, mismatched);
        $fatal(1, "watchdog expired");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_word_valid"}, bus.word_valid, 0);
        check({tag, "_frame_err"}, bus.frame_err, 0);
        check({tag, "_word_addr"}, bus.word_addr, 0);
        check({tag, "_word_data"}, bus.word_data, 0);
        check({tag, "_period_cnt"}, bus.period_cnt, 0);
        check({tag, "_ovf_sticky"}, bus.ovf_sticky, 0);
        check({tag, "_rd_data"}, bus.rd_data, 0);
    endtask

    int cnt_before;
    int ticks_before;

    initial begin
        bus.serial_in     = 1'b0;
        bus.sl_in         = 1'b0;
        bus.addr_in       = 4'd0;
        bus.ovf_rtc_in    = 1'b0;
        bus.ovf_global_in = 1'b0;
        bus.rd_addr       = 4'd0;

        // Power-on reset.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick_step();

        // Good frame to channel 3, address wiggles after bit 0 must be ignored.
        send_frame(4'd3, 8'hA5, 8, 1);
        rand_rd = 1'b0;
        bus.rd_addr = 4'd3;
        #1;
        check("rd_ch3_after_commit", bus.rd_data, 8'hA5);
        rand_rd = 1'b1;

        // Short frame leaves channel 3 untouched.
        send_frame(4'd3, 8'h3C, 5, 2);
        rand_rd = 1'b0;
        bus.rd_addr = 4'd3;
        #1;
        check("rd_ch3_after_short", bus.rd_data, 8'hA5);
        rand_rd = 1'b1;

        // Overlong burst gives a single error, then a normal frame still commits.
        send_frame(4'd1, 8'h77, 12, 1);
        send_frame(4'd0, 8'hFF, 8, 2);

        // Out-of-range channel.
        send_frame(4'd9, 8'h42, 8, 2);
        rand_rd = 1'b0;
        bus.rd_addr = 4'd9;
        #1;
        check("rd_ch9_is_zero", bus.rd_data, 8'h00);
        rand_rd = 1'b1;

        // Reset in the middle of a frame.
        for (int i = 0; i < 4; i++) begin
            bus.sl_in = 1'b1;
            bus.serial_in = 1'b1;
            bus.addr_in = 4'd2;
            tick_step();
        end
        #2;
        rst_n = 1'b0;
        bus.sl_in = 1'b0;
        #1;
        check_all_zero("midreset");
        tick_step();
        rst_n = 1'b1;
        tick_step();
        send_frame(4'd2, 8'h5A, 8, 2);
        #1;
        check("word_data_after_reset", bus.word_data, 8'h5A);
        check("word_addr_after_reset", bus.word_addr, 4'd2);

        // 256 RTC edges with the level held for three cycles each.
        bus.ovf_rtc_in = 1'b0;
        tick_step();
        cnt_before   = int'(m_cnt);
        ticks_before = tick_seen;
        for (int k = 0; k < 256; k++) begin
            bus.ovf_rtc_in = 1'b1;
            repeat (3) tick_step();
            bus.ovf_rtc_in = 1'b0;
            repeat (2) tick_step();
        end
        check("rtc_tick_count", tick_seen - ticks_before, 256);
        check("period_cnt_wrap", bus.period_cnt, cnt_before);

        // Global overflow sets the flag, next RTC edge clears it.
        bus.ovf_global_in = 1'b1;
        tick_step();
        bus.ovf_global_in = 1'b0;
        #3;
        check("sticky_set", bus.ovf_sticky, 1);
        bus.ovf_rtc_in = 1'b1;
        tick_step();
        #3;
        check("sticky_cleared", bus.ovf_sticky, 0);
        bus.ovf_rtc_in = 1'b0;
        tick_step();
        bus.ovf_rtc_in = 1'b1;
        bus.ovf_global_in = 1'b1;
        tick_step();
        bus.ovf_global_in = 1'b0;
        #3;
        check("sticky_set_wins", bus.ovf_sticky, 1);
        bus.ovf_rtc_in = 1'b0;
        tick_step();

        // Randomized traffic with random side-band activity.
        rand_side = 1'b1;
        for (int k = 0; k < 200; k++) begin
            logic [3:0] a;
            count_t     d;
            int         nb;
            a  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            d  = 8'($urandom);
            nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 12)) : 8;
            send_frame(a, d, nb, int'($urandom_range(1, 3)));
        end
        rand_side = 1'b0;
        bus.ovf_global_in = 1'b0;
        repeat (4) tick_step();
        check("events_outstanding", evq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
